// File: rtl/mbist_mem_arb.sv
// Round-robin arbiter sharing one MBIST SRAM port between the wishbone host
// and the BIST engine, with burst lock, bounded-hold preemption and read routing.
module mbist_mem_arb #(
  parameter int BIST_NO_SRAM = 4,
  parameter int BIST_ADDR_WD = 9,
  parameter int BIST_DATA_WD = 32,
  parameter int HOLD_MAX     = 16,
  localparam int CSW         = (BIST_NO_SRAM + 1) / 2
) (
  input  logic                    wb_clk_i,
  input  logic                    rst_n,
  input  logic                    hst_req,
  input  logic                    hst_lock,
  input  logic [CSW-1:0]          hst_cs,
  input  logic [BIST_ADDR_WD-1:0] hst_addr,
  input  logic                    hst_we,
  input  logic [3:0]              hst_wmask,
  input  logic [BIST_DATA_WD-1:0] hst_wdata,
  input  logic                    bst_req,
  input  logic                    bst_lock,
  input  logic [CSW-1:0]          bst_cs,
  input  logic [BIST_ADDR_WD-1:0] bst_addr,
  input  logic                    bst_we,
  input  logic [3:0]              bst_wmask,
  input  logic [BIST_DATA_WD-1:0] bst_wdata,
  output logic                    hst_gnt,
  output logic                    bst_gnt,
  output logic                    hst_rvalid,
  output logic                    bst_rvalid,
  output logic [BIST_DATA_WD-1:0] rdata,
  output logic                    mem_req,
  output logic [CSW-1:0]          mem_cs,
  output logic [BIST_ADDR_WD-1:0] mem_addr,
  output logic                    mem_we,
  output logic [3:0]              mem_wmask,
  output logic [BIST_DATA_WD-1:0] mem_wdata,
  input  logic [BIST_DATA_WD-1:0] mem_rdata
);

  // Encoding chosen so each grant is a plain state flop bit (glitch-free outputs).
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_HST = 2'b01,
    GNT_BST = 2'b10
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_reg;
  logic       last_bst_reg;
  logic [7:0] hold_cnt_reg;
  logic       tag0_vld_reg, tag0_bst_reg;
  logic       tag1_vld_reg, tag1_bst_reg;

  logic   own_hst, own_bst;
  logic   x_req, x_lock, y_req, preempt;
  state_t other_state;

  assign own_hst     = state_reg[0];
  assign own_bst     = state_reg[1];
  assign x_req       = own_hst ? hst_req  : bst_req;
  assign x_lock      = own_hst ? hst_lock : bst_lock;
  assign y_req       = own_hst ? bst_req  : hst_req;
  assign other_state = own_hst ? GNT_BST  : GNT_HST;
  assign preempt     = y_req && !x_lock && (HOLD_MAX != 0) && (hold_cnt_reg == HOLD_LAST);

  assign hst_gnt = own_hst;
  assign bst_gnt = own_bst;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_bst_reg <= 1'b1;
      hold_cnt_reg <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          hold_cnt_reg <= 8'd0;
          if (hst_req && (!bst_req || last_bst_reg))
            state_reg <= GNT_HST;
          else if (bst_req)
            state_reg <= GNT_BST;
        end
        GNT_HST, GNT_BST: begin
          if (!x_req && !x_lock) begin
            state_reg    <= y_req ? other_state : IDLE;
            last_bst_reg <= own_bst;
            hold_cnt_reg <= 8'd0;
          end else if (x_lock || !y_req) begin
            hold_cnt_reg <= 8'd0;
          end else if (preempt) begin
            state_reg    <= other_state;
            last_bst_reg <= own_bst;
            hold_cnt_reg <= 8'd0;
          end else if (hold_cnt_reg != 8'hFF) begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_cs    = '0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (own_hst) begin
      mem_req   = hst_req;
      mem_cs    = hst_cs;
      mem_addr  = hst_addr;
      mem_we    = hst_we;
      mem_wmask = hst_wmask;
      mem_wdata = hst_wdata;
    end else if (own_bst) begin
      mem_req   = bst_req;
      mem_cs    = bst_cs;
      mem_addr  = bst_addr;
      mem_we    = bst_we;
      mem_wmask = bst_wmask;
      mem_wdata = bst_wdata;
    end
  end

  // Tags travel with the read, so a grant change never reroutes data in flight.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tag0_vld_reg <= 1'b0;
      tag0_bst_reg <= 1'b0;
      tag1_vld_reg <= 1'b0;
      tag1_bst_reg <= 1'b0;
    end else begin
      tag0_vld_reg <= mem_req & ~mem_we;
      tag0_bst_reg <= own_bst;
      tag1_vld_reg <= tag0_vld_reg;
      tag1_bst_reg <= tag0_bst_reg;
    end
  end

  assign hst_rvalid = tag1_vld_reg & ~tag1_bst_reg;
  assign bst_rvalid = tag1_vld_reg &  tag1_bst_reg;
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_mbist_mem_arb.sv
// Directed and randomized bench for mbist_mem_arb, checked every cycle against
// an owner/queue reference model of the arbitration and read-return rules.
module tb_mbist_mem_arb;
  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int CSW = 2;
  localparam int HM  = 16;

  logic wb_clk_i = 1'b0;
  logic rst_n    = 1'b0;
  logic hst_req, hst_lock, hst_we, bst_req, bst_lock, bst_we;
  logic [CSW-1:0] hst_cs, bst_cs, mem_cs;
  logic [AW-1:0]  hst_addr, bst_addr, mem_addr;
  logic [3:0]     hst_wmask, bst_wmask, mem_wmask;
  logic [DW-1:0]  hst_wdata, bst_wdata, mem_wdata, rdata;
  logic [DW-1:0]  mem_rdata = '0;
  logic hst_gnt, bst_gnt, hst_rvalid, bst_rvalid, mem_req, mem_we;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner 0=none 1=host 2=BIST; pipe holds the owner id of reads in flight.
  int m_owner, m_last, m_run;
  int m_pipe[$];

  always #5 wb_clk_i = ~wb_clk_i;

  mbist_mem_arb #(.BIST_NO_SRAM(4), .BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .HOLD_MAX(HM)) dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n),
    .hst_req(hst_req), .hst_lock(hst_lock), .hst_cs(hst_cs), .hst_addr(hst_addr),
    .hst_we(hst_we), .hst_wmask(hst_wmask), .hst_wdata(hst_wdata),
    .bst_req(bst_req), .bst_lock(bst_lock), .bst_cs(bst_cs), .bst_addr(bst_addr),
    .bst_we(bst_we), .bst_wmask(bst_wmask), .bst_wdata(bst_wdata),
    .hst_gnt(hst_gnt), .bst_gnt(bst_gnt), .hst_rvalid(hst_rvalid), .bst_rvalid(bst_rvalid),
    .rdata(rdata), .mem_req(mem_req), .mem_cs(mem_cs), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hst_req = 0; hst_lock = 0; hst_we = 0; hst_cs = '0; hst_addr = '0; hst_wmask = '0; hst_wdata = '0;
    bst_req = 0; bst_lock = 0; bst_we = 0; bst_cs = '0; bst_addr = '0; bst_wmask = '0; bst_wdata = '0;
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_run = 0;
    m_pipe = '{0, 0};
  endtask

  task automatic check_outputs();
    logic [AW+CSW+5:0] exp_bus;
    logic [DW-1:0]     exp_wd;
    int rv;
    exp_bus = '0; exp_wd = '0;
    if (m_owner == 1) begin
      exp_bus = {hst_req, hst_cs, hst_addr, hst_we, hst_wmask}; exp_wd = hst_wdata;
    end else if (m_owner == 2) begin
      exp_bus = {bst_req, bst_cs, bst_addr, bst_we, bst_wmask}; exp_wd = bst_wdata;
    end
    rv = m_pipe[0];
    chk("hst_gnt", hst_gnt, m_owner == 1);
    chk("bst_gnt", bst_gnt, m_owner == 2);
    chk("mem_bus", {mem_req, mem_cs, mem_addr, mem_we, mem_wmask}, exp_bus);
    chk("mem_wdata", mem_wdata, exp_wd);
    chk("hst_rvalid", hst_rvalid, rv == 1);
    chk("bst_rvalid", bst_rvalid, rv == 2);
    chk("rdata", rdata, mem_rdata);
  endtask

  // Applies the arbitration rules to the inputs seen at this clock edge.
  task automatic model_update();
    logic xr, xl, yr, xwe;
    int other;
    xr = (m_owner == 1) ? hst_req  : bst_req;
    xl = (m_owner == 1) ? hst_lock : bst_lock;
    yr = (m_owner == 1) ? bst_req  : hst_req;
    xwe = (m_owner == 1) ? hst_we : bst_we;
    void'(m_pipe.pop_front());
    m_pipe.push_back((m_owner != 0 && xr && !xwe) ? m_owner : 0);
    other = 3 - m_owner;
    if (m_owner == 0) begin
      m_run = 0;
      if (hst_req && bst_req) m_owner = (m_last == 2) ? 1 : 2;
      else if (hst_req)       m_owner = 1;
      else if (bst_req)       m_owner = 2;
    end else if (!xr && !xl) begin
      m_last = m_owner; m_owner = yr ? other : 0; m_run = 0;
    end else if (xl || !yr) begin
      m_run = 0;
    end else begin
      m_run++;
      if (HM != 0 && m_run >= HM) begin
        m_last = m_owner; m_owner = other; m_run = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge wb_clk_i);
    check_outputs();
    @(posedge wb_clk_i);
    model_update();
    #1;
    mem_rdata = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge wb_clk_i);
    #1;
    chk("rst_gnt", {hst_gnt, bst_gnt}, 2'b00);
    chk("rst_rvalid", {hst_rvalid, bst_rvalid}, 2'b00);
    chk("rst_mem_req", mem_req, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_h, n_b, n_rv;
    clear_inputs();
    model_reset();
    do_reset();

    // Single host read at 0x005
    hst_req = 1; hst_addr = 9'h005; hst_cs = 2'd1;
    step();
    chk("t1_hst_gnt", hst_gnt, 1);
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 9'h005);
    chk("t1_mem_cs", mem_cs, 2'd1);
    step();
    hst_req = 0;
    step();
    chk("t1_hst_rvalid", hst_rvalid, 1);
    chk("t1_bst_rvalid", bst_rvalid, 0);
    step();
    chk("t1_rvalid_done", hst_rvalid, 0);

    // Tie, handover without idle gap, second tie
    do_reset();
    hst_req = 1; bst_req = 1;
    step();
    chk("t2_tie_host", {hst_gnt, bst_gnt}, 2'b10);
    hst_req = 0;
    step();
    chk("t2_handover", {hst_gnt, bst_gnt}, 2'b01);
    bst_req = 0;
    step();
    chk("t2_idle", {hst_gnt, bst_gnt}, 2'b00);
    hst_req = 1; bst_req = 1;
    step();
    chk("t2_tie2_host", {hst_gnt, bst_gnt}, 2'b10);

    // Bounded-hold preemption both ways
    do_reset();
    hst_req = 1; bst_req = 1;
    step();
    n_h = 0;
    for (int g = 0; g < 60 && hst_gnt; g++) begin n_h++; step(); end
    chk("t3_host_cycles", n_h, HM);
    chk("t3_bst_gnt", bst_gnt, 1);
    n_b = 0;
    for (int g = 0; g < 60 && bst_gnt; g++) begin n_b++; step(); end
    chk("t3_bst_cycles", n_b, HM);
    chk("t3_host_regnt", hst_gnt, 1);

    // Locked 32-beat host read burst with BIST waiting
    do_reset();
    hst_req = 1; hst_lock = 1; bst_req = 1;
    step();
    n_rv = 0;
    for (int i = 0; i < 32; i++) begin
      chk("t4_lock_hold", hst_gnt, 1);
      hst_addr = 9'(i);
      step();
      n_rv += int'(hst_rvalid);
    end
    hst_req = 0; hst_lock = 0;
    step();
    n_rv += int'(hst_rvalid);
    chk("t4_bst_gnt", bst_gnt, 1);
    step();
    n_rv += int'(hst_rvalid);
    chk("t4_rvalid_count", n_rv, 32);

    // Trailing host reads survive the grant switch
    do_reset();
    hst_req = 1; bst_req = 1;
    step();
    for (int g = 0; g < 40 && !bst_gnt; g++) step();
    chk("t5_trail1", {hst_rvalid, bst_rvalid}, 2'b10);
    step();
    chk("t5_trail2", {hst_rvalid, bst_rvalid}, 2'b10);
    step();
    chk("t5_bst_first", {hst_rvalid, bst_rvalid}, 2'b01);

    // Asynchronous reset in the middle of a locked burst
    do_reset();
    hst_req = 1; hst_lock = 1; bst_req = 1;
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_gnt_drop", {hst_gnt, bst_gnt}, 2'b00);
    chk("t6_rvalid_drop", {hst_rvalid, bst_rvalid}, 2'b00);
    chk("t6_mem_req", mem_req, 0);
    do_reset();
    hst_req = 1; bst_req = 1;
    step();
    chk("t6_tie_host", {hst_gnt, bst_gnt}, 2'b10);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      hst_req   = ($urandom_range(0, 3) != 0);
      hst_lock  = ($urandom_range(0, 7) == 0);
      hst_we    = $urandom_range(0, 1);
      hst_cs    = CSW'($urandom);
      hst_addr  = AW'($urandom);
      hst_wmask = 4'($urandom);
      hst_wdata = $urandom;
      bst_req   = ($urandom_range(0, 2) != 0);
      bst_lock  = ($urandom_range(0, 9) == 0);
      bst_we    = $urandom_range(0, 1);
      bst_cs    = CSW'($urandom);
      bst_addr  = AW'($urandom);
      bst_wmask = 4'($urandom);
      bst_wdata = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
